// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the multi-port register file.
// Provides default sizes, the address-width derivation and read-port status.
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    // Address width for a register count; a 1-bit address is the minimum.
    function automatic int aw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Read-port status as seen by the decode stage.
    typedef enum logic [1:0] {
        RD_READY = 2'd0,
        RD_BUSY  = 2'd1,
        RD_FWD   = 2'd2
    } rd_status_t;

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Bundle between decode/writeback (master) and the register file (slave).
// Carries read ports, issue claim handshake and the writeback port.
interface regfile_mp_sb_if #(
    parameter int XLEN  = regfile_pkg::XLEN_DEF,
    parameter int NREG  = regfile_pkg::NREG_DEF,
    parameter int NREAD = 2
) ();
    import regfile_pkg::*;

    localparam int AW = aw_of(NREG);

    logic [NREAD*AW-1:0]   raddr;
    logic [NREAD*XLEN-1:0] rdata;
    logic [NREAD-1:0]      rbusy;
    logic                  iss_valid;
    logic [AW-1:0]         iss_rd;
    logic                  iss_ready;
    logic                  we;
    logic [AW-1:0]         waddr;
    logic [XLEN-1:0]       wdata;

    modport master (
        output raddr, iss_valid, iss_rd, we, waddr, wdata,
        input  rdata, rbusy, iss_ready
    );

    modport slave (
        input  raddr, iss_valid, iss_rd, we, waddr, wdata,
        output rdata, rbusy, iss_ready
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits with issue/writeback priority (issue wins).
// Ports: clk, rst_n, iss_valid/iss_rd, we/waddr in; busy vector, iss_ready out.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG    = NREG_DEF,
    parameter int AW      = aw_of(NREG),
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    output logic [NREG-1:0] busy,
    output logic            iss_ready
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            zero_rd;

    assign zero_rd = ZERO_R0 && (iss_rd == '0);

    // A writeback retiring this cycle frees the slot for a new claim.
    assign iss_ready = zero_rd || !busy_q[iss_rd]
                     || (we && (waddr == iss_rd));

    always_comb begin
        busy_d = busy_q;
        if (we) begin
            busy_d[waddr] = 1'b0;
        end
        // Applied after the clear: a new producer owns the register.
        if (iss_valid && iss_ready) begin
            busy_d[iss_rd] = 1'b1;
        end
        if (ZERO_R0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Parametrised register file: NREAD combinational reads, one write,
// optional write bypass and zero register, plus a busy scoreboard.
// Ports: clk, rst_n (async, active low), bus (slave side of the bundle).
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NREG    = NREG_DEF,
    parameter int NREAD   = 2,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    regfile_mp_sb_if.slave  bus
);

    localparam int AW = aw_of(NREG);

    logic [XLEN-1:0]       regs_q [NREG];
    logic [XLEN-1:0]       regs_d [NREG];
    logic [NREG-1:0]       busy;
    logic                  iss_ready;
    logic                  wr_en;
    logic [NREAD*XLEN-1:0] rdata_c;
    logic [NREAD-1:0]      rbusy_c;
    logic [AW-1:0]         ra;
    logic                  hit;

    // Gated by rst_n so nothing is forwarded while the array is held clear.
    assign wr_en = bus.we && rst_n
                 && !(ZERO_R0 && (bus.waddr == '0));

    regfile_scoreboard #(
        .NREG    (NREG),
        .AW      (AW),
        .ZERO_R0 (ZERO_R0)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (bus.iss_valid),
        .iss_rd    (bus.iss_rd),
        .we        (bus.we),
        .waddr     (bus.waddr),
        .busy      (busy),
        .iss_ready (iss_ready)
    );

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[bus.waddr] = bus.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rdata_c = '0;
        rbusy_c = '0;
        ra      = '0;
        hit     = 1'b0;
        for (int k = 0; k < NREAD; k++) begin
            ra  = bus.raddr[k*AW +: AW];
            hit = BYPASS && wr_en && (bus.waddr == ra);
            // A forwarded value is no longer outstanding for the reader.
            rdata_c[k*XLEN +: XLEN] = hit ? bus.wdata : regs_q[ra];
            rbusy_c[k]              = hit ? 1'b0 : busy[ra];
            if (ZERO_R0 && (ra == '0)) begin
                rdata_c[k*XLEN +: XLEN] = '0;
                rbusy_c[k]              = 1'b0;
            end
        end
    end

    assign bus.rdata     = rdata_c;
    assign bus.rbusy     = rbusy_c;
    assign bus.iss_ready = iss_ready;

endmodule
